// File: rtl/plab5_mcore_dma_engine_pkg.sv
// Shared types and constants for the DMA engine: FSM states, vc-mem type codes,
// command control field layout and the word-count decode helper.
package plab5_mcore_dma_engine_pkg;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_RD_REQ  = 3'd1,
      ST_RD_WAIT = 3'd2,
      ST_WR_REQ  = 3'd3,
      ST_WR_WAIT = 3'd4,
      ST_DONE    = 3'd5
   } state_e;

   localparam int unsigned C_TYPE_NBITS      = 3;
   localparam logic [2:0]  C_TYPE_READ       = 3'd0;
   localparam logic [2:0]  C_TYPE_WRITE      = 3'd1;
   localparam int unsigned C_CTRL_OPAQUE_LSB = 36;
   localparam int unsigned C_CTRL_LEN_NBITS  = 4;

   // A zero word-count field means a full 16-word burst.
   function automatic logic [4:0] decode_len(input logic [3:0] field);
      decode_len = (field == 4'd0) ? 5'd16 : {1'b0, field};
   endfunction

endpackage

// File: rtl/plab5_mcore_dma_engine_if.sv
// Command (checker side) and vc-mem (network side) signal bundle of the DMA engine.
interface plab5_mcore_dma_engine_if #(
   parameter int unsigned p_opaque_nbits = 8,
   parameter int unsigned p_addr_nbits   = 32,
   parameter int unsigned p_data_nbits   = 32
);
   localparam int unsigned c_len_nbits   = $clog2(p_data_nbits / 8);
   localparam int unsigned c_req_cnbits  = 3 + p_opaque_nbits + p_addr_nbits + c_len_nbits;
   localparam int unsigned c_req_nbits   = c_req_cnbits + p_data_nbits;
   localparam int unsigned c_resp_cnbits = 3 + p_opaque_nbits + c_len_nbits;
   localparam int unsigned c_resp_nbits  = c_resp_cnbits + p_data_nbits;

   logic                      dma_val;
   logic                      dma_rdy;
   logic [p_addr_nbits-1:0]   dma_src_addr;
   logic [p_addr_nbits-1:0]   dma_dest_addr;
   logic [c_req_cnbits-1:0]   dma_req_control;
   logic                      dma_inst;
   logic                      dma_domain;
   logic                      dma_ack;
   logic                      dma_ack_err;
   logic                      dma_ack_domain;
   logic                      memreq_val;
   logic                      memreq_rdy;
   logic [c_req_nbits-1:0]    memreq_msg;
   logic                      memreq_domain;
   logic                      memresp_val;
   logic                      memresp_rdy;
   logic [c_resp_nbits-1:0]   memresp_msg;

   modport slave (
      input  dma_val, dma_src_addr, dma_dest_addr, dma_req_control, dma_inst, dma_domain,
      output dma_rdy, dma_ack, dma_ack_err, dma_ack_domain,
      output memreq_val, memreq_msg, memreq_domain,
      input  memreq_rdy,
      input  memresp_val, memresp_msg,
      output memresp_rdy
   );

   modport master (
      output dma_val, dma_src_addr, dma_dest_addr, dma_req_control, dma_inst, dma_domain,
      input  dma_rdy, dma_ack, dma_ack_err, dma_ack_domain,
      input  memreq_val, memreq_msg, memreq_domain,
      output memreq_rdy,
      output memresp_val, memresp_msg,
      input  memresp_rdy
   );

endinterface

// File: rtl/plab5_mcore_dma_engine_addr_gen.sv
// Word counter plus word-aligned source/destination address pointers for one copy.
module plab5_mcore_dma_engine_addr_gen #(
   parameter int unsigned p_addr_nbits = 32
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    load_i,
   input  logic [p_addr_nbits-1:0] src_i,
   input  logic [p_addr_nbits-1:0] dest_i,
   input  logic [4:0]              len_i,
   input  logic                    advance_i,
   output logic [p_addr_nbits-1:0] src_addr_o,
   output logic [p_addr_nbits-1:0] dest_addr_o,
   output logic [4:0]              idx_o,
   output logic                    last_o
);
   localparam logic [p_addr_nbits-1:0] c_word_bytes = {{(p_addr_nbits-3){1'b0}}, 3'd4};

   logic [p_addr_nbits-1:0] src_q;
   logic [p_addr_nbits-1:0] dest_q;
   logic [4:0]              idx_q;
   logic [4:0]              len_q;

   // Pointers wrap naturally at the top of the address space.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         src_q  <= '0;
         dest_q <= '0;
         idx_q  <= 5'd0;
         len_q  <= 5'd0;
      end else if (load_i) begin
         src_q  <= {src_i[p_addr_nbits-1:2], 2'b00};
         dest_q <= {dest_i[p_addr_nbits-1:2], 2'b00};
         idx_q  <= 5'd0;
         len_q  <= len_i;
      end else if (advance_i) begin
         src_q  <= src_q + c_word_bytes;
         dest_q <= dest_q + c_word_bytes;
         idx_q  <= idx_q + 5'd1;
      end
   end

   assign src_addr_o  = src_q;
   assign dest_addr_o = dest_q;
   assign idx_o       = idx_q;
   assign last_o      = (idx_q == (len_q - 5'd1));

endmodule

// File: rtl/plab5_mcore_dma_engine.sv
// DMA copy engine: read-then-write word loop over vc-mem, ack with command domain.
// Optional source/destination bounds check enabled by PLAB5_MCORE_DMA_BOUNDS_EN.
module plab5_mcore_dma_engine
   import plab5_mcore_dma_engine_pkg::*;
#(
   parameter int unsigned             p_opaque_nbits = 8,
   parameter int unsigned             p_addr_nbits   = 32,
   parameter int unsigned             p_data_nbits   = 32,
   parameter logic [p_addr_nbits-1:0] p_secure_base  = 32'h0001_0000
) (
   input  logic                        clk,
   input  logic                        reset,
   plab5_mcore_dma_engine_if.slave     bus
);
   localparam int unsigned c_len_nbits  = $clog2(p_data_nbits / 8);
   localparam int unsigned c_resp_nbits = 3 + p_opaque_nbits + c_len_nbits + p_data_nbits;

   state_e                    state_q;
   logic                      dma_rdy_q;
   logic                      ack_q;
   logic                      memreq_val_q;
   logic                      memresp_rdy_q;
   logic                      domain_q;
   logic [p_opaque_nbits-1:0] opaque_q;
   logic [p_data_nbits-1:0]   data_q;

   logic [4:0]                len_s;
   logic                      load_s;
   logic                      advance_s;
   logic                      reject_s;
   logic [p_addr_nbits-1:0]   src_addr_s;
   logic [p_addr_nbits-1:0]   dest_addr_s;
   logic [4:0]                idx_s;
   logic                      last_s;
   logic [C_TYPE_NBITS-1:0]   req_type_s;
   logic [p_addr_nbits-1:0]   req_addr_s;
   logic [p_data_nbits-1:0]   req_data_s;

   assign len_s     = decode_len(bus.dma_req_control[C_CTRL_LEN_NBITS-1:0]);
   assign load_s    = (state_q == ST_IDLE) && bus.dma_val;
   assign advance_s = (state_q == ST_WR_WAIT) && bus.memresp_val && !last_s;

   plab5_mcore_dma_engine_addr_gen #(.p_addr_nbits(p_addr_nbits)) u_addr_gen (
      .clk         (clk),
      .reset       (reset),
      .load_i      (load_s),
      .src_i       (bus.dma_src_addr),
      .dest_i      (bus.dma_dest_addr),
      .len_i       (len_s),
      .advance_i   (advance_s),
      .src_addr_o  (src_addr_s),
      .dest_addr_o (dest_addr_s),
      .idx_o       (idx_s),
      .last_o      (last_s)
   );

`ifdef PLAB5_MCORE_DMA_BOUNDS_EN
   logic [p_addr_nbits:0] span_s;
   logic [p_addr_nbits:0] src_end_s;
   logic [p_addr_nbits:0] dest_end_s;
   logic                  err_q;

   // Highest byte touched, computed one bit wider so a wrapping range still trips the check.
   assign span_s     = {{(p_addr_nbits-6){1'b0}}, len_s, 2'b00} - {{p_addr_nbits{1'b0}}, 1'b1};
   assign src_end_s  = {1'b0, bus.dma_src_addr[p_addr_nbits-1:2], 2'b00} + span_s;
   assign dest_end_s = {1'b0, bus.dma_dest_addr[p_addr_nbits-1:2], 2'b00} + span_s;
   assign reject_s   = !bus.dma_domain &&
                       ((src_end_s >= {1'b0, p_secure_base}) || (dest_end_s >= {1'b0, p_secure_base}));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         err_q <= 1'b0;
      end else if (load_s) begin
         err_q <= reject_s;
      end else if (state_q == ST_DONE) begin
         err_q <= 1'b0;
      end
   end

   assign bus.dma_ack_err = err_q;
`else
   logic unused_base_s;
   assign unused_base_s   = ^p_secure_base;
   assign reject_s        = 1'b0;
   assign bus.dma_ack_err = 1'b0;
`endif

   // Control FSM; handshake outputs are set on the transition into the state that owns them.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q       <= ST_IDLE;
         dma_rdy_q     <= 1'b1;
         ack_q         <= 1'b0;
         memreq_val_q  <= 1'b0;
         memresp_rdy_q <= 1'b0;
         domain_q      <= 1'b0;
         opaque_q      <= '0;
         data_q        <= '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (bus.dma_val) begin
                  domain_q  <= bus.dma_domain;
                  opaque_q  <= bus.dma_req_control[C_CTRL_OPAQUE_LSB +: p_opaque_nbits];
                  dma_rdy_q <= 1'b0;
                  if (reject_s) begin
                     state_q <= ST_DONE;
                     ack_q   <= 1'b1;
                  end else begin
                     state_q      <= ST_RD_REQ;
                     memreq_val_q <= 1'b1;
                  end
               end
            end
            ST_RD_REQ: begin
               if (bus.memreq_rdy) begin
                  state_q       <= ST_RD_WAIT;
                  memreq_val_q  <= 1'b0;
                  memresp_rdy_q <= 1'b1;
               end
            end
            ST_RD_WAIT: begin
               if (bus.memresp_val) begin
                  state_q       <= ST_WR_REQ;
                  data_q        <= bus.memresp_msg[p_data_nbits-1:0];
                  memresp_rdy_q <= 1'b0;
                  memreq_val_q  <= 1'b1;
               end
            end
            ST_WR_REQ: begin
               if (bus.memreq_rdy) begin
                  state_q       <= ST_WR_WAIT;
                  memreq_val_q  <= 1'b0;
                  memresp_rdy_q <= 1'b1;
               end
            end
            ST_WR_WAIT: begin
               if (bus.memresp_val) begin
                  memresp_rdy_q <= 1'b0;
                  if (last_s) begin
                     state_q <= ST_DONE;
                     ack_q   <= 1'b1;
                  end else begin
                     state_q      <= ST_RD_REQ;
                     memreq_val_q <= 1'b1;
                  end
               end
            end
            ST_DONE: begin
               state_q   <= ST_IDLE;
               ack_q     <= 1'b0;
               dma_rdy_q <= 1'b1;
            end
            default: begin
               state_q       <= ST_IDLE;
               dma_rdy_q     <= 1'b1;
               ack_q         <= 1'b0;
               memreq_val_q  <= 1'b0;
               memresp_rdy_q <= 1'b0;
            end
         endcase
      end
   end

   // Request fields come only from registers, so the message is stable while stalled.
   always_comb begin
      req_type_s = C_TYPE_READ;
      req_addr_s = src_addr_s;
      req_data_s = '0;
      if (state_q == ST_WR_REQ) begin
         req_type_s = C_TYPE_WRITE;
         req_addr_s = dest_addr_s;
         req_data_s = data_q;
      end else begin
         req_type_s = C_TYPE_READ;
         req_addr_s = src_addr_s;
      end
   end

   assign bus.memreq_msg     = {req_type_s, {{(p_opaque_nbits-5){1'b0}}, idx_s}, req_addr_s,
                                {c_len_nbits{1'b0}}, req_data_s};
   assign bus.memreq_val     = memreq_val_q;
   assign bus.memreq_domain  = domain_q;
   assign bus.memresp_rdy    = memresp_rdy_q;
   assign bus.dma_rdy        = dma_rdy_q;
   assign bus.dma_ack        = ack_q;
   assign bus.dma_ack_domain = domain_q;

   logic unused_s;
   assign unused_s = ^{bus.dma_inst, bus.dma_req_control, opaque_q,
                       bus.memresp_msg[c_resp_nbits-1:p_data_nbits]};

endmodule
